// File: rtl/pr_iter_scheduler_if.sv
// Memory and datapath side-band bundle for the PageRank iteration scheduler.
// master = scheduler, slave = node table / edge list / rank BRAMs and divider datapath.
interface pr_iter_scheduler_if #(
    parameter int NUM_NODES = 16,
    parameter int ADDR_W    = 8,
    parameter int DW        = 32
);
    localparam int NID_W = $clog2(NUM_NODES);

    logic [NID_W-1:0]  nt_addr;
    logic [ADDR_W-1:0] nt_base;
    logic [3:0]        nt_fanin;

    logic [ADDR_W-1:0] edge_addr;
    logic [NID_W-1:0]  edge_src;

    logic [NID_W:0]    src_addr;

    logic              dp_start;
    logic [3:0]        dp_ip_count;
    logic              dp_load;
    logic              dp_done;
    logic [DW-1:0]     dp_result;

    logic              pr_we;
    logic [NID_W:0]    pr_waddr;
    logic [DW-1:0]     pr_wdata;

    modport master (
        output nt_addr,
        input  nt_base, nt_fanin,
        output edge_addr,
        input  edge_src,
        output src_addr,
        output dp_start, dp_ip_count, dp_load,
        input  dp_done, dp_result,
        output pr_we, pr_waddr, pr_wdata
    );

    modport slave (
        input  nt_addr,
        output nt_base, nt_fanin,
        input  edge_addr,
        output edge_src,
        input  src_addr,
        input  dp_start, dp_ip_count, dp_load,
        output dp_done, dp_result,
        input  pr_we, pr_waddr, pr_wdata
    );
endinterface

// File: rtl/pr_iter_scheduler.sv
// PageRank iteration sequencer: feeds in-neighbour operands to the divider/adder datapath and
// writes each node's new rank to the opposite ping-pong bank. Define PR_SCHED_DAMPING_EN for damping.
//
// state     | meaning
// IDLE      | waiting for start
// NODE_RD   | node-table address presented
// NODE_WAIT | node-table data valid; clamp fan-in, kick datapath
// FEED      | edge/rank pipeline, one operand per cycle
// WAIT_DP   | waiting for datapath result
// MUL       | damping multiply (PR_SCHED_DAMPING_EN only)
// WRITE     | rank write strobe
// NEXT      | advance node / iteration
// DONE      | completion pulse
module pr_iter_scheduler #(
    parameter int NUM_NODES = 16,
    parameter int MAX_FANIN = 10,
    parameter int NUM_ITER  = 20,
    parameter int ADDR_W    = 8,
    parameter int DW        = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       err_fanin,
    output logic [7:0]                 iter_cnt,
    pr_iter_scheduler_if.master        bus
);
    localparam int NID_W = $clog2(NUM_NODES);
    localparam logic [3:0]       MAX_FANIN_W = 4'(MAX_FANIN);
    localparam logic [NID_W-1:0] LAST_NODE   = NID_W'(NUM_NODES - 1);
    localparam logic [7:0]       ITER_LAST   = 8'(NUM_ITER);

    typedef enum logic [3:0] {
        S_IDLE,
        S_NODE_RD,
        S_NODE_WAIT,
        S_FEED,
        S_WAIT_DP,
`ifdef PR_SCHED_DAMPING_EN
        S_MUL,
`endif
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [NID_W-1:0]  node_q, node_d;
    logic              rd_bank_q, rd_bank_d;
    logic [7:0]        iter_q, iter_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              dp_start_q, dp_start_d;
    logic [3:0]        dp_cnt_q, dp_cnt_d;
    logic              dp_load_q, dp_load_d;
    logic              src_vld_q, src_vld_d;
    logic [3:0]        rem_q, rem_d;
    logic [ADDR_W-1:0] edge_addr_q, edge_addr_d;
    logic [DW-1:0]     result_q, result_d;
    logic              pr_we_q, pr_we_d;
    logic [NID_W:0]    pr_waddr_q, pr_waddr_d;
    logic [DW-1:0]     pr_wdata_q, pr_wdata_d;

    logic              fanin_over;
    logic [3:0]        n_eff;
    logic [DW-1:0]     wr_value;

    assign fanin_over = (bus.nt_fanin > MAX_FANIN_W);
    assign n_eff      = fanin_over ? MAX_FANIN_W : bus.nt_fanin;

`ifdef PR_SCHED_DAMPING_EN
    localparam logic [DW-1:0] PR_D    = DW'(32'h0000_D99A);
    localparam logic [DW-1:0] PR_BASE = DW'((32'h0001_0000 - 32'h0000_D99A) / NUM_NODES);

    logic [2*DW-1:0] prod;
    assign prod     = {{DW{1'b0}}, result_q} * {{DW{1'b0}}, PR_D};
    assign wr_value = PR_BASE + prod[DW+15:16];
`endif

    always_comb begin
        state_d     = state_q;
        node_d      = node_q;
        rd_bank_d   = rd_bank_q;
        iter_d      = iter_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        dp_start_d  = 1'b0;
        dp_cnt_d    = dp_cnt_q;
        dp_load_d   = src_vld_q;
        src_vld_d   = 1'b0;
        rem_d       = rem_q;
        edge_addr_d = edge_addr_q;
        result_d    = result_q;
        pr_we_d     = 1'b0;
        pr_waddr_d  = pr_waddr_q;
        pr_wdata_d  = pr_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d     = 1'b0;
                    iter_d    = 8'd0;
                    node_d    = '0;
                    rd_bank_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_NODE_RD;
                end
            end
            S_NODE_RD: state_d = S_NODE_WAIT;
            S_NODE_WAIT: begin
                if (fanin_over) err_d = 1'b1;
                if (n_eff == 4'd0) begin
                    result_d = '0;
`ifdef PR_SCHED_DAMPING_EN
                    state_d  = S_MUL;
`else
                    state_d  = S_WRITE;
`endif
                end else begin
                    dp_start_d  = 1'b1;
                    dp_cnt_d    = n_eff;
                    rem_d       = n_eff;
                    edge_addr_d = bus.nt_base;
                    state_d     = S_FEED;
                end
            end
            S_FEED: begin
                // rem_q counts edge reads still to issue; loads trail them by two cycles
                if (rem_q != 4'd0) begin
                    rem_d     = rem_q - 4'd1;
                    src_vld_d = 1'b1;
                    if (rem_q != 4'd1) edge_addr_d = edge_addr_q + 1'b1;
                end else if (dp_load_q && !src_vld_q) begin
                    state_d = S_WAIT_DP;
                end
            end
            S_WAIT_DP: begin
                if (bus.dp_done) begin
                    result_d = bus.dp_result;
`ifdef PR_SCHED_DAMPING_EN
                    state_d  = S_MUL;
`else
                    state_d  = S_WRITE;
`endif
                end
            end
`ifdef PR_SCHED_DAMPING_EN
            S_MUL: state_d = S_WRITE;
`endif
            S_WRITE: state_d = S_NEXT;
            S_NEXT: begin
                if (node_q != LAST_NODE) begin
                    node_d  = node_q + 1'b1;
                    state_d = S_NODE_RD;
                end else begin
                    node_d    = '0;
                    rd_bank_d = ~rd_bank_q;
                    iter_d    = iter_q + 8'd1;
                    if (iter_d == ITER_LAST) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_NODE_RD;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifndef PR_SCHED_DAMPING_EN
        wr_value = result_d;
`endif
        if (state_d == S_WRITE) begin
            pr_we_d    = 1'b1;
            pr_waddr_d = {~rd_bank_q, node_q};
            pr_wdata_d = wr_value;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            node_q      <= '0;
            rd_bank_q   <= 1'b0;
            iter_q      <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            dp_start_q  <= 1'b0;
            dp_cnt_q    <= 4'd0;
            dp_load_q   <= 1'b0;
            src_vld_q   <= 1'b0;
            rem_q       <= 4'd0;
            edge_addr_q <= '0;
            result_q    <= '0;
            pr_we_q     <= 1'b0;
            pr_waddr_q  <= '0;
            pr_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            node_q      <= node_d;
            rd_bank_q   <= rd_bank_d;
            iter_q      <= iter_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            dp_start_q  <= dp_start_d;
            dp_cnt_q    <= dp_cnt_d;
            dp_load_q   <= dp_load_d;
            src_vld_q   <= src_vld_d;
            rem_q       <= rem_d;
            edge_addr_q <= edge_addr_d;
            result_q    <= result_d;
            pr_we_q     <= pr_we_d;
            pr_waddr_q  <= pr_waddr_d;
            pr_wdata_q  <= pr_wdata_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign err_fanin       = err_q;
    assign iter_cnt        = iter_q;
    assign bus.nt_addr     = node_q;
    assign bus.edge_addr   = edge_addr_q;
    // edge_src arrives a cycle after edge_addr, so the rank address is formed combinationally from it
    assign bus.src_addr    = src_vld_q ? {rd_bank_q, bus.edge_src} : '0;
    assign bus.dp_start    = dp_start_q;
    assign bus.dp_ip_count = dp_cnt_q;
    assign bus.dp_load     = dp_load_q;
    assign bus.pr_we       = pr_we_q;
    assign bus.pr_waddr    = pr_waddr_q;
    assign bus.pr_wdata    = pr_wdata_q;
endmodule

// File: tb/tb_pr_iter_scheduler.sv
// Directed bench for pr_iter_scheduler: 8-node graph, 2 iterations, behavioural BRAMs and datapath,
// expected rank writes queued from an independent PageRank model.
module tb_pr_iter_scheduler;
    localparam int NN = 8;
    localparam int MF = 10;
    localparam int NI = 2;

    logic       clk;
    logic       reset;
    logic       start;
    logic       busy, done, err_fanin;
    logic [7:0] iter_cnt;

    pr_iter_scheduler_if #(.NUM_NODES(NN), .ADDR_W(8), .DW(32)) bus ();

    pr_iter_scheduler #(.NUM_NODES(NN), .MAX_FANIN(MF), .NUM_ITER(NI), .ADDR_W(8), .DW(32)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .err_fanin(err_fanin), .iter_cnt(iter_cnt), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // graph: node -> (fan-in, edge-list base)
    logic [3:0]  fan_tab  [NN] = '{4'd3, 4'd0, 4'd12, 4'd1, 4'd2, 4'd10, 4'd1, 4'd15};
    logic [7:0]  base_tab [NN] = '{8'h10, 8'h00, 8'hF8, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    logic [2:0]  edge_mem [256];
    logic [31:0] rank_mem [16];

    function automatic logic [31:0] init_rank(int idx);
        return 32'h0000_1000 * 32'(idx + 1);
    endfunction

    initial begin
        for (int a = 0; a < 256; a++) edge_mem[a] = 3'((a * 5 + 3) % 8);
        edge_mem[8'h10] = 3'd2;
        edge_mem[8'h11] = 3'd5;
        edge_mem[8'h12] = 3'd7;
        for (int i = 0; i < 16; i++) rank_mem[i] = init_rank(i);
    end

    always @(posedge clk) begin
        bus.nt_base  <= base_tab[bus.nt_addr];
        bus.nt_fanin <= fan_tab[bus.nt_addr];
        bus.edge_src <= edge_mem[bus.edge_addr];
    end

    logic [31:0] rank_rd;
    logic [31:0] odeg_rd;
    always @(posedge clk) begin
        rank_rd <= rank_mem[bus.src_addr];
        odeg_rd <= 32'(bus.src_addr[2:0]) + 32'd1;
        if (bus.pr_we) rank_mem[bus.pr_waddr] <= bus.pr_wdata;
    end

    // datapath model: sums (rank + out-degree) of loaded operands, result after dp_delay cycles
    int          dp_delay;
    int          dp_cnt;
    int          dp_loads;
    int          dp_want;
    logic [31:0] dp_acc;
    always @(negedge clk) begin
        if (!reset) begin
            bus.dp_done   = 1'b0;
            bus.dp_result = 32'd0;
            dp_cnt        = -1;
        end else begin
            if (bus.dp_start) begin
                dp_acc      = 32'd0;
                dp_loads    = 0;
                dp_want     = int'(bus.dp_ip_count);
                bus.dp_done = 1'b0;
                dp_cnt      = -1;
            end
            if (bus.dp_load) begin
                dp_acc   = dp_acc + rank_rd + odeg_rd;
                dp_loads = dp_loads + 1;
                if (dp_loads == dp_want) dp_cnt = dp_delay;
            end
            if (dp_cnt == 0) begin
                bus.dp_done   = 1'b1;
                bus.dp_result = dp_acc;
                dp_cnt        = -1;
            end else if (dp_cnt > 0) begin
                dp_cnt = dp_cnt - 1;
            end
        end
    end

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        int          n;
    } wr_t;

    wr_t         wq [$];
    logic [31:0] m_rank [2][NN];
    int          n_vec = 0;
    int          n_err = 0;
    int          starts_seen, loads_seen, done_seen, writes_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] damp(logic [31:0] s);
`ifdef PR_SCHED_DAMPING_EN
        logic [63:0] p;
        p = 64'(s) * 64'h0000_D99A;
        return 32'd1228 + p[47:16];
`else
        return s;
`endif
    endfunction

    task automatic push_run();
        int          mb;
        int          n;
        logic [7:0]  a;
        logic [2:0]  src;
        logic [31:0] sum;
        wr_t         e;
        mb = 0;
        for (int it = 0; it < NI; it++) begin
            for (int nd = 0; nd < NN; nd++) begin
                n   = (int'(fan_tab[nd]) > MF) ? MF : int'(fan_tab[nd]);
                sum = 32'd0;
                for (int k = 0; k < n; k++) begin
                    a   = 8'(int'(base_tab[nd]) + k);
                    src = edge_mem[a];
                    sum = sum + m_rank[mb][src] + 32'(src) + 32'd1;
                end
                e.addr = {1'(1 - mb), 3'(nd)};
                e.data = damp(sum);
                e.n    = n;
                m_rank[1 - mb][nd] = e.data;
                wq.push_back(e);
            end
            mb = 1 - mb;
        end
    endtask

    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (bus.dp_start) begin
            if (wq.size() != 0) chk("dp_ip_count", 64'(bus.dp_ip_count), 64'(wq[0].n));
            starts_seen++;
        end
        if (bus.dp_load) loads_seen++;
        if (done) begin
            done_seen++;
            chk("busy_at_done", 64'(busy), 64'd0);
        end
        if (bus.pr_we) begin
            chk("wr_expected", 64'(wq.size() != 0), 64'd1);
            if (wq.size() != 0) begin
                e = wq.pop_front();
                chk("wr_addr", 64'(bus.pr_waddr), 64'(e.addr));
                chk("wr_data", 64'(bus.pr_wdata), 64'(e.data));
                chk("wr_loads", 64'(loads_seen), 64'(e.n));
                chk("wr_starts", 64'(starts_seen), 64'(e.n != 0));
            end
            writes_seen++;
            loads_seen  = 0;
            starts_seen = 0;
        end
    endtask

    task automatic clear_counts();
        starts_seen = 0;
        loads_seen  = 0;
        done_seen   = 0;
        writes_seen = 0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c;
        c = 0;
        while (!done && c < budget) begin
            tick();
            c++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    task automatic end_of_run(input string tag);
        chk({tag, "_iter_cnt"}, 64'(iter_cnt), 64'(NI));
        chk({tag, "_err_fanin"}, 64'(err_fanin), 64'd1);
        chk({tag, "_writes"}, 64'(writes_seen), 64'(NN * NI));
        chk({tag, "_queue_empty"}, 64'(wq.size()), 64'd0);
        tick();
        tick();
        chk({tag, "_done_pulse"}, 64'(done_seen), 64'd1);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int c;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NN; i++) m_rank[b][i] = init_rank(b * NN + i);
        clear_counts();
        dp_delay = 4;
        reset    = 1'b0;
        start    = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pr_we", 64'(bus.pr_we), 64'd0);
        chk("rst_dp_load", 64'(bus.dp_load), 64'd0);
        chk("rst_dp_start", 64'(bus.dp_start), 64'd0);
        chk("rst_err", 64'(err_fanin), 64'd0);
        chk("rst_iter", 64'(iter_cnt), 64'd0);
        chk("rst_addrs", {bus.nt_addr, bus.edge_addr, bus.src_addr, bus.pr_waddr}, 64'd0);
        start = 1'b0;
        reset = 1'b1;
        tick();

        // run A: dp_done 4 cycles after last load, stray start mid-run
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("A_busy_after_start", 64'(busy), 64'd1);
        c = 0;
        while (!done && c < 3000) begin
            tick();
            c++;
            if (c == 30) start = 1'b1;
            if (c == 31) begin
                start = 1'b0;
                chk("A_busy_mid", 64'(busy), 64'd1);
            end
        end
        chk("A_done_seen", 64'(done), 64'd1);
        end_of_run("A");

        // run B: dp_done coincident with last load, err_fanin cleared by start
        clear_counts();
        dp_delay = 0;
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("B_err_cleared", 64'(err_fanin), 64'd0);
        chk("B_iter_cleared", 64'(iter_cnt), 64'd0);
        wait_done("B_done_seen", 3000);
        end_of_run("B");

        // run C: reset while waiting on the datapath, nothing may be written afterwards
        clear_counts();
        dp_delay = 40;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (!bus.dp_load && c < 200) begin
            tick();
            c++;
        end
        chk("C_load_seen", 64'(bus.dp_load), 64'd1);
        c = 0;
        while (bus.dp_load && c < 50) begin
            tick();
            c++;
        end
        tick();
        chk("C_busy_before_rst", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("C_busy_async", 64'(busy), 64'd0);
        chk("C_pr_we_async", 64'(bus.pr_we), 64'd0);
        tick();
        chk("C_busy_rst", 64'(busy), 64'd0);
        chk("C_iter_rst", 64'(iter_cnt), 64'd0);
        tick();
        reset = 1'b1;
        repeat (80) tick();
        chk("C_no_writes", 64'(writes_seen), 64'd0);
        chk("C_idle", 64'(busy), 64'd0);
        chk("C_no_done", 64'(done_seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
